// File: rtl/gmii_pkg.sv
// Shared constants and types for the GMII receive/transmit FCS blocks.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Register value left after running payload plus its own FCS through the CRC.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    S_DROP,
    S_IDLE,
    S_PRE,
    S_BODY
  } rx_state_t;

endpackage

// File: rtl/crc32_byte_step.sv
// One byte of reflected CRC-32 (LSB first), fully unrolled and combinational.
// Meant to be reused by the TX FCS appender as well.
module crc32_byte_step
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Eight shift/xor steps, one per data bit
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_fcs_check.sv
// GMII receive FCS checker: strips preamble/SFD/FCS, forwards payload bytes and
// raises a one-cycle status pulse per frame.
// Optional frame statistics counters are enabled with GMII_FCS_CHK_STATS_EN.
module gmii_rx_fcs_check
  import gmii_pkg::*;
#(
  parameter int unsigned MIN_BODY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_dv_in,
  input  logic        gmii_er_in,
  input  logic [7:0]  gmii_data_in,
  output logic        out_dv,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        frame_err
`ifdef GMII_FCS_CHK_STATS_EN
  ,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt,
  output logic [31:0] runt_cnt
`endif
);

  localparam logic [3:0] MIN_BODY_C = 4'(MIN_BODY);

  logic            dv_r;
  logic            er_r;
  logic [7:0]      data_r;
  rx_state_t       state;
  logic [31:0]     crc;
  logic [31:0]     crc_next;
  logic [3:0]      count;
  logic            err;
  logic [3:0][7:0] dly;
  logic            eof;
  logic            eof_runt;
  logic            eof_good;

  crc32_byte_step u_crc_step (
    .crc_in  (crc),
    .data    (data_r),
    .crc_out (crc_next)
  );

  assign eof      = (state == S_BODY) && !dv_r;
  assign eof_runt = count < MIN_BODY_C;
  assign eof_good = (crc == CRC32_RESIDUE) && !eof_runt && !err;

  // Input capture; left free-running so a frame in flight across reset stays visible
  always_ff @(posedge clk) begin
    dv_r   <= gmii_dv_in;
    er_r   <= gmii_er_in;
    data_r <= gmii_data_in;
  end

  // Frame FSM with delay-line datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_DROP;
      crc        <= CRC32_INIT;
      count      <= 4'd0;
      err        <= 1'b0;
      dly        <= '0;
      out_dv     <= 1'b0;
      out_sof    <= 1'b0;
      out_data   <= 8'h00;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_dv     <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_DROP: begin
          if (!dv_r) state <= S_IDLE;
        end
        // IDLE treats the first dv byte exactly like a preamble byte
        S_IDLE, S_PRE: begin
          if (!dv_r) begin
            state <= S_IDLE;
          end else if (data_r == PREAMBLE_BYTE) begin
            state <= S_PRE;
          end else if (data_r == SFD_BYTE) begin
            state <= S_BODY;
            crc   <= CRC32_INIT;
            count <= 4'd0;
            err   <= 1'b0;
          end else begin
            state <= S_DROP;
          end
        end
        S_BODY: begin
          if (dv_r) begin
            crc <= crc_next;
            dly <= {dly[2:0], data_r};
            if (count != 4'd15) count <= count + 4'd1;
            if (er_r) err <= 1'b1;
            // Line full: oldest byte is known not to be part of the FCS
            if (count >= 4'd4) begin
              out_dv   <= 1'b1;
              out_data <= dly[3];
              out_sof  <= (count == 4'd4);
            end
          end else begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
            crc_ok     <= eof_good;
            frame_err  <= err | eof_runt;
          end
        end
        default: state <= S_DROP;
      endcase
    end
  end

`ifdef GMII_FCS_CHK_STATS_EN
  // Statistics, updated together with the frame_done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= 32'd0;
      bad_cnt  <= 32'd0;
      runt_cnt <= 32'd0;
    end else if (eof) begin
      if (eof_good) good_cnt <= good_cnt + 32'd1;
      else          bad_cnt  <= bad_cnt + 32'd1;
      if (eof_runt) runt_cnt <= runt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Self-checking bench for gmii_rx_fcs_check: directed frames plus randomized
// frames, compared against a frame-level reference model.
module tb_gmii_rx_fcs_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gmii_dv_in = 1'b0;
  logic       gmii_er_in = 1'b0;
  logic [7:0] gmii_data_in = 8'h00;
  logic       out_dv, out_sof, frame_done, crc_ok, frame_err;
  logic [7:0] out_data;
`ifdef GMII_FCS_CHK_STATS_EN
  logic [31:0] good_cnt, bad_cnt, runt_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] got_data[$];
  logic       got_sof[$];
  int         got_cyc[$];
  logic       got_ok[$];
  logic       got_err[$];
  logic [7:0] exp_data[$];
  logic       exp_sof[$];
  int         exp_cyc[$];
  logic       exp_ok[$];
  logic       exp_err[$];
  int         mdl_good = 0;
  int         mdl_bad = 0;
  int         mdl_runt = 0;

  gmii_rx_fcs_check #(.MIN_BODY(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .gmii_dv_in   (gmii_dv_in),
    .gmii_er_in   (gmii_er_in),
    .gmii_data_in (gmii_data_in),
    .out_dv       (out_dv),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .frame_done   (frame_done),
    .crc_ok       (crc_ok),
    .frame_err    (frame_err)
`ifdef GMII_FCS_CHK_STATS_EN
    ,
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt),
    .runt_cnt     (runt_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect everything the DUT emits
  always @(negedge clk) begin
    if (!rst) begin
      if (out_dv) begin
        got_data.push_back(out_data);
        got_sof.push_back(out_sof);
        got_cyc.push_back(cyc);
      end
      if (frame_done) begin
        got_ok.push_back(crc_ok);
        got_err.push_back(frame_err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Standard Ethernet CRC-32 of a whole message (complemented result)
  function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    gmii_dv_in   = dv;
    gmii_er_in   = er;
    gmii_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Sends preamble, SFD and body (payload+FCS or runt) and records expectations
  task automatic send_frame(input int pre_len, input logic [7:0] body[$], input int er_idx);
    logic [7:0]  pay[$];
    logic [31:0] fcs;
    logic        runt, has_er, fcs_match, ok;
    int          n;
    n = body.size();
    for (int i = 0; i < pre_len; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int k = 0; k < n; k++) begin
      if (k < n - 4) begin
        exp_data.push_back(body[k]);
        exp_sof.push_back(k == 0);
        exp_cyc.push_back(cyc + 6);
      end
      drive(1'b1, (k == er_idx), body[k]);
    end
    gmii_dv_in = 1'b0;
    gmii_er_in = 1'b0;
    runt   = (n < 4);
    has_er = (er_idx >= 0) && (er_idx < n);
    fcs_match = 1'b0;
    if (!runt) begin
      for (int k = 0; k < n - 4; k++) pay.push_back(body[k]);
      fcs = crc32_ref(pay);
      fcs_match = (body[n-4] == fcs[7:0]) && (body[n-3] == fcs[15:8]) &&
                  (body[n-2] == fcs[23:16]) && (body[n-1] == fcs[31:24]);
    end
    ok = fcs_match && !runt && !has_er;
    exp_ok.push_back(ok);
    exp_err.push_back(has_er || runt);
    if (ok) mdl_good++;
    else    mdl_bad++;
    if (runt) mdl_runt++;
  endtask

  function automatic void mk_good(input logic [7:0] pay[$], output logic [7:0] body[$]);
    logic [31:0] fcs;
    fcs  = crc32_ref(pay);
    body = pay;
    body.push_back(fcs[7:0]);
    body.push_back(fcs[15:8]);
    body.push_back(fcs[23:16]);
    body.push_back(fcs[31:24]);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_nbytes"}, got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      chk({tag, "_data"}, {24'h0, got_data[i]}, {24'h0, exp_data[i]});
      chk({tag, "_sof"}, {31'h0, got_sof[i]}, {31'h0, exp_sof[i]});
      chk({tag, "_latency"}, got_cyc[i], exp_cyc[i]);
    end
    chk({tag, "_nframes"}, got_ok.size(), exp_ok.size());
    for (int i = 0; i < exp_ok.size() && i < got_ok.size(); i++) begin
      chk({tag, "_crc_ok"}, {31'h0, got_ok[i]}, {31'h0, exp_ok[i]});
      chk({tag, "_frame_err"}, {31'h0, got_err[i]}, {31'h0, exp_err[i]});
    end
    got_data.delete(); got_sof.delete(); got_cyc.delete(); got_ok.delete(); got_err.delete();
    exp_data.delete(); exp_sof.delete(); exp_cyc.delete(); exp_ok.delete(); exp_err.delete();
  endtask

  initial begin
    logic [7:0] ref_body[$];
    logic [7:0] body[$];
    logic [7:0] pay[$];
    int         kind, plen, er_idx;

    ref_body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_dv", out_dv, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_crc_ok", crc_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    gap(3);

    // Known-good "123456789" frame
    send_frame(7, ref_body, -1);
    gap(4);
    check_all("good_ref");
    chk("crc_ok_held", crc_ok, 1);

    // Single corrupted payload byte
    body = ref_body;
    body[4] = 8'h34;
    send_frame(7, body, -1);
    gap(4);
    check_all("corrupt");

    // Runt: three body bytes
    body = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(7, body, -1);
    gap(4);
    check_all("runt");
    chk("runt_err_held", frame_err, 1);

    // RX_ER on third body byte
    send_frame(7, ref_body, 2);
    gap(4);
    check_all("rx_er");

    // Bad preamble, one-cycle gap, then a good frame
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h12);
    drive(1'b1, 1'b0, 8'hD5);
    drive(1'b1, 1'b0, 8'h31);
    drive(1'b1, 1'b0, 8'h32);
    gap(1);
    send_frame(7, ref_body, -1);
    gap(4);
    check_all("bad_pre");

    // Randomized frames, gaps of 1..3 cycles
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      pay.delete();
      body.delete();
      er_idx = -1;
      if (kind == 0) begin
        plen = $urandom_range(0, 3);
        for (int i = 0; i < plen; i++) body.push_back(8'($urandom_range(0, 255)));
      end else begin
        plen = $urandom_range(0, 30);
        for (int i = 0; i < plen; i++) pay.push_back(8'($urandom_range(0, 255)));
        mk_good(pay, body);
        if (kind == 1) begin
          int idx = $urandom_range(0, body.size() - 1);
          body[idx] = body[idx] ^ 8'($urandom_range(1, 255));
        end
        if (kind == 2) er_idx = $urandom_range(0, body.size() - 1);
      end
      send_frame($urandom_range(1, 8), body, er_idx);
      gap($urandom_range(1, 3));
    end
    gap(4);
    check_all("random");
`ifdef GMII_FCS_CHK_STATS_EN
    chk("rand_good_cnt", good_cnt, mdl_good);
    chk("rand_bad_cnt", bad_cnt, mdl_bad);
    chk("rand_runt_cnt", runt_cnt, mdl_runt);
`endif

    // Reset mid-body with dv held high
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h46);
    chk("midrst_out_dv", out_dv, 0);
    chk("midrst_out_sof", out_sof, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_crc_ok", crc_ok, 0);
    rst = 1'b0;
    got_data.delete(); got_sof.delete(); got_cyc.delete(); got_ok.delete(); got_err.delete();
    exp_data.delete(); exp_sof.delete(); exp_cyc.delete(); exp_ok.delete(); exp_err.delete();
    mdl_good = 0;
    mdl_bad  = 0;
    mdl_runt = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h60 + i));
    gap(2);
    send_frame(7, ref_body, -1);
    gap(4);
    check_all("after_rst");
    chk("after_rst_crc_ok", crc_ok, 1);
`ifdef GMII_FCS_CHK_STATS_EN
    chk("after_rst_good_cnt", good_cnt, 1);
    chk("after_rst_bad_cnt", bad_cnt, 0);
    chk("after_rst_runt_cnt", runt_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
